// File: rtl/fifo_tx.sv
// Transmit FIFO: a circular buffer that is filled by wr_en and drained one
// byte per next_frame once start_tx opens a transmit session.
module fifo_tx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16   // must be a power of two so the pointers wrap naturally
) (
  input  logic              clk_fifo_tx,
  input  logic              rst_fifo_tx,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              start_tx,
  input  logic              next_frame,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_tx_status
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_next;
  logic [DATA_W-1:0]   r_data_out;
  logic                w_tx_active;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;

  assign w_tx_active = (r_state == ST_TX);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_pop       = w_tx_active && next_frame && !w_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
  assign w_push      = wr_en && (!w_full || w_pop);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start_tx && !w_empty)  w_state_next = ST_TX;
      ST_TX:   if (w_count_next == '0)    w_state_next = ST_IDLE;
      default:                            w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_fifo_tx) begin
    if (rst_fifo_tx) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_data_out <= r_mem[r_rd_ptr];
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; after reset the
  // pointers and count make every old entry unreachable, and leaving it
  // reset-free lets it map onto plain RAM.
  always_ff @(posedge clk_fifo_tx) begin
    if (w_push && !rst_fifo_tx) r_mem[r_wr_ptr] <= data_in;
  end

  assign data_out       = r_data_out;
  assign fifo_tx_status = w_tx_active;

endmodule

// File: tb/tb_fifo_tx.sv
// Directed bench for fifo_tx: partial transfer, full/overflow, empty start,
// concurrent write+pop, pointer wrap-around and reset during transmission.
module tb_fifo_tx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk_fifo_tx;
  logic              rst_fifo_tx;
  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              start_tx;
  logic              next_frame;
  logic [DATA_W-1:0] data_out;
  logic              fifo_tx_status;

  int n_checks;
  int n_fail;

  fifo_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_fifo_tx    (clk_fifo_tx),
    .rst_fifo_tx    (rst_fifo_tx),
    .data_in        (data_in),
    .wr_en          (wr_en),
    .start_tx       (start_tx),
    .next_frame     (next_frame),
    .data_out       (data_out),
    .fifo_tx_status (fifo_tx_status)
  );

  initial clk_fifo_tx = 1'b0;
  always #5 clk_fifo_tx = ~clk_fifo_tx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk_fifo_tx);
    #1;
  endtask

  task automatic do_reset();
    rst_fifo_tx = 1'b1;
    tick();
    rst_fifo_tx = 1'b0;
  endtask

  task automatic write_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      data_in = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start();
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    check("start_status", 32'(fifo_tx_status), 32'd1);
  endtask

  // Pop n bytes expected as base, base+1, ...; status must drop with the last one.
  task automatic drain(input string tag, input logic [7:0] base, input int n);
    next_frame = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_data"},   32'(data_out),       32'(base + 8'(i)));
      check({tag, "_status"}, 32'(fifo_tx_status), (i == n - 1) ? 32'd0 : 32'd1);
    end
    next_frame = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_fifo_tx = 1'b0;
    data_in     = '0;
    wr_en       = 1'b0;
    start_tx    = 1'b0;
    next_frame  = 1'b0;

    // Reset state
    do_reset();
    check("rst_data",   32'(data_out),       32'h00);
    check("rst_status", 32'(fifo_tx_status), 32'd0);

    // Partial transfer; next_frame during the start cycle must be ignored
    write_bytes(8'h01, 5);
    start_tx   = 1'b1;
    next_frame = 1'b1;
    tick();
    start_tx = 1'b0;
    check("p_start_status", 32'(fifo_tx_status), 32'd1);
    check("p_start_data",   32'(data_out),       32'h00);
    drain("partial", 8'h01, 5);
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    check("p_hold_data",   32'(data_out),       32'h05);
    check("p_hold_status", 32'(fifo_tx_status), 32'd0);

    // Full and overflow (pointers start mid-buffer, so this also wraps)
    write_bytes(8'h10, 16);
    write_bytes(8'h20, 1);
    start();
    drain("full", 8'h10, 16);
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    check("ovf_hold_data",   32'(data_out),       32'h1F);
    check("ovf_hold_status", 32'(fifo_tx_status), 32'd0);

    // Empty start
    do_reset();
    start_tx   = 1'b1;
    next_frame = 1'b1;
    tick();
    tick();
    start_tx   = 1'b0;
    next_frame = 1'b0;
    check("empty_status", 32'(fifo_tx_status), 32'd0);
    check("empty_data",   32'(data_out),       32'h00);

    // Concurrent write and pop at count==1
    do_reset();
    write_bytes(8'h55, 1);
    start();
    next_frame = 1'b1;
    wr_en      = 1'b1;
    data_in    = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("conc_data1",   32'(data_out),       32'h55);
    check("conc_status1", 32'(fifo_tx_status), 32'd1);
    tick();
    next_frame = 1'b0;
    check("conc_data2",   32'(data_out),       32'hAA);
    check("conc_status2", 32'(fifo_tx_status), 32'd0);

    // Write into a full FIFO together with a pop is accepted
    do_reset();
    write_bytes(8'h30, 16);
    start();
    next_frame = 1'b1;
    wr_en      = 1'b1;
    data_in    = 8'h40;
    tick();
    wr_en = 1'b0;
    check("fullpop_data",   32'(data_out),       32'h30);
    check("fullpop_status", 32'(fifo_tx_status), 32'd1);
    drain("fullpop", 8'h31, 16);

    // Wrap-around; start_tx held while transmitting has no effect
    do_reset();
    write_bytes(8'h50, 12);
    start();
    start_tx = 1'b1;
    drain("wrap1", 8'h50, 12);
    start_tx = 1'b0;
    write_bytes(8'h60, 10);
    start();
    drain("wrap2", 8'h60, 10);

    // Reset mid-transmission
    do_reset();
    write_bytes(8'h70, 5);
    start();
    next_frame = 1'b1;
    tick();
    check("mid_pop1", 32'(data_out), 32'h70);
    tick();
    check("mid_pop2", 32'(data_out), 32'h71);
    rst_fifo_tx = 1'b1;
    tick();
    rst_fifo_tx = 1'b0;
    next_frame  = 1'b0;
    check("mid_rst_data",   32'(data_out),       32'h00);
    check("mid_rst_status", 32'(fifo_tx_status), 32'd0);
    start_tx = 1'b1;
    tick();
    start_tx   = 1'b0;
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    check("mid_restart_status", 32'(fifo_tx_status), 32'd0);
    check("mid_restart_data",   32'(data_out),       32'h00);
    write_bytes(8'h99, 1);
    start();
    drain("mid_new", 8'h99, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_tx.md
FIFO_TX -- requirements
Module: fifo_tx

Interface
REQ-001 Parameter DATA_W, default 8: data byte width in bits.
REQ-002 Parameter DEPTH, default 16: number of FIFO entries; SHALL be a power of two.
REQ-003 Port clk_fifo_tx, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_fifo_tx, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port data_in, input, DATA_W bits: byte to be written into the FIFO.
REQ-006 Port wr_en, input, 1 bit: write strobe, sampled every cycle.
REQ-007 Port start_tx, input, 1 bit: request to begin draining the FIFO; a partially filled FIFO is valid.
REQ-008 Port next_frame, input, 1 bit: consumer request for the next byte while transmitting.
REQ-009 Port data_out, output, DATA_W bits: registered, holds the most recently popped byte.
REQ-010 Port fifo_tx_status, output, 1 bit: high while a transmission is in progress.

Function
REQ-011 Storage SHALL be a circular buffer of DEPTH x DATA_W, with log2(DEPTH)-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-012 An occupancy count SHALL run 0..DEPTH (log2(DEPTH)+1 bits); empty is count==0 and full is count==DEPTH.
REQ-013 Write: wr_en=1 and not full -> mem[wr_ptr]<=data_in, wr_ptr+1, count+1; wr_en=1 while full SHALL be ignored, with no state change.
REQ-014 Internal flag tx_active drives the output: fifo_tx_status = tx_active.
REQ-015 Idle (tx_active=0) to transmit: start_tx=1 and not empty -> tx_active<=1 on that edge; start_tx while empty SHALL be ignored.
REQ-016 start_tx while tx_active=1 SHALL have no effect.
REQ-017 Pop: tx_active=1, next_frame=1 and not empty -> data_out<=mem[rd_ptr], rd_ptr+1, count-1; one byte per cycle, data visible in the cycle after the sampling edge.
REQ-018 next_frame SHALL be ignored while tx_active=0, including the cycle in which start_tx is sampled.
REQ-019 Transmit to idle: tx_active<=0 on the same edge as the pop that leaves the FIFO empty; fifo_tx_status falls together with the last byte appearing on data_out.
REQ-020 Simultaneous write and pop in one cycle: both SHALL execute, and count stays unchanged.
REQ-021 A pop with a simultaneous write while count==1 SHALL keep tx_active=1, because the FIFO is not left empty.
REQ-022 A write into a full FIFO with a simultaneous pop SHALL be accepted, since the pop frees a slot that same cycle.
REQ-023 Writes during transmission are allowed and the new bytes are transmitted in the same session.
REQ-024 data_out SHALL hold its value when no pop occurs.
REQ-025 Bytes SHALL be delivered in strict write order (FIFO), including across pointer wrap-around.

Reset
REQ-026 rst_fifo_tx=1 at a rising edge SHALL set wr_ptr, rd_ptr, count, tx_active and data_out to 0, overriding all other inputs in that cycle.
REQ-027 Memory contents need not be cleared; they are unreachable after reset.
REQ-028 Reset asserted mid-transmission SHALL discard all stored bytes and drop fifo_tx_status on that edge.

Verification
REQ-029 Partial transfer: reset, write 01..05, pulse start_tx, then hold next_frame=1 -> data_out 01,02,03,04,05 on consecutive cycles; fifo_tx_status=1 until the edge that outputs 05, then 0.
REQ-030 Full and overflow: write 16 bytes 10..1F, then a 17th byte 20 -> 20 dropped; the drain yields exactly 10..1F.
REQ-031 Empty start: with no writes, pulse start_tx and next_frame -> fifo_tx_status stays 0 and data_out stays 00.
REQ-032 Concurrent: while transmitting with count==1, write AA in the same cycle as a pop -> status stays 1, and the next pop outputs AA and drops status.
REQ-033 Wrap-around: write, transmit and drain 12 bytes, then write and drain 10 more -> order preserved across the pointer wrap.
REQ-034 Reset mid-run: reset after two of five pops -> data_out=00, status=0, and a following start_tx is ignored until new writes.
